intermed_wire_arbiter: RTL and testbench
========================================

// Module: intermed_wire_arbiter
// PURPOSE
//   Shares one AND/OR logic evaluation unit between NUM_REQ requesters.
//   Unit function: mid = a & b; out_1 = mid | c; out_2 = mid & b.
//   Round-robin arbiter picks one requester, captures its three operand bits,
//   evaluates them in the shared unit and returns a registered, tagged result
//   under a valid/ready handshake. Sits between the requesting blocks and the
//   logic unit.
// PARAMETERS
//   NUM_REQ  4   number of requesters (>=1)
//   ID_W     2   width of rsp_id; must be >= max(1, $clog2(NUM_REQ))
//   CNT_W    16  width of txn_count
// PORTS
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous reset, active-high
//   req        in   NUM_REQ  req[i]=1: requester i wants one evaluation
//   req_in_1   in   NUM_REQ  operand a of requester i (bit i)
//   req_in_2   in   NUM_REQ  operand b of requester i (bit i)
//   req_in_3   in   NUM_REQ  operand c of requester i (bit i)
//   gnt        out  NUM_REQ  one-hot, 1-cycle pulse: operands of i captured
//   busy       out  1        1 whenever state != IDLE
//   rsp_valid  out  1        result available
//   rsp_ready  in   1        consumer accepts result
//   rsp_id     out  ID_W     index of requester owning the result
//   rsp_out_1  out  1        (a & b) | c of the captured operands
//   rsp_out_2  out  1        (a & b) & b of the captured operands
//   txn_count  out  CNT_W    completed handshakes, wraps at 2^CNT_W
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, gnt=0, busy=0, rsp_valid=0,
//     rsp_id=0, rsp_out_1=0, rsp_out_2=0, txn_count=0, rr pointer=0.
//   FSM: IDLE -> GRANT -> EVAL -> RESP -> IDLE.
//   IDLE:  if |req at a clock edge, the winner w is chosen and the next state
//          is GRANT. On that edge gnt<=onehot(w), and a/b/c of w are captured
//          into internal registers. If req==0, stay in IDLE.
//   GRANT: gnt high for exactly this cycle. Next state EVAL; gnt<=0.
//   EVAL:  the shared unit computes from the captured bits. On the edge:
//          rsp_out_1/2 <= results, rsp_id <= w, rsp_valid <= 1,
//          next state RESP.
//   RESP:  rsp_valid and all rsp_* held stable until rsp_valid&rsp_ready at an
//          edge. On that edge: rsp_valid<=0, txn_count<=txn_count+1, next
//          state IDLE.
//   Latency: req sampled at edge k -> gnt high cycle k+1 -> rsp_valid high
//     from cycle k+3. Max throughput 1 result / 4 cycles with rsp_ready=1.
//   Arbitration: round-robin. Search starts at index ptr and wraps modulo
//     NUM_REQ. After a grant to w, ptr<=(w+1) mod NUM_REQ. At reset ptr=0, so
//     req 0 has first priority.
//   req is sampled only in IDLE. Changes to req or operands while busy are
//     ignored. A requester drops req after its gnt pulse; if req[w] is still
//     high in the next IDLE, it is treated as a new request.
//   Operands are sampled only on the capture edge; later changes do not
//     affect the result.
//   NUM_REQ=1: ptr is constant 0 and rsp_id is always 0.
//   rst during any state aborts the transaction: the result is lost and
//     txn_count is not incremented.
//   rsp_ready is ignored outside RESP.
// TESTING
//   1 Reset mid-RESP (rsp_valid=1) -> all outputs 0 immediately, without
//     waiting for a clock edge. Next req[0] is granted first.
//   2 req=4'b0001, a/b/c=1/1/0 (bit0), rsp_ready=1 -> gnt=0001 one cycle,
//     rsp_valid 2 cycles later, rsp_id=0, out_1=1, out_2=1, txn_count=1.
//   3 req=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; one gnt every
//     4 cycles; rsp_id follows the same order.
//   4 rsp_ready=0 for 10 cycles in RESP with req=4'b0110 -> rsp_* stable,
//     gnt=0, busy=1. On release, the next grant goes to ptr's first requester.
//   5 Exhaust all 8 a/b/c combos on req 2 -> out_1=(a&b)|c, out_2=a&b,
//     each with rsp_id=2.
//   6 Change the operands of the granted requester in the EVAL cycle -> the
//     result reflects the captured values. With CNT_W=2, 5 handshakes give
//     txn_count=1 (wrap).

Source files
------------

// File: rtl/intermed_wire_arbiter.sv
// intermed_wire_arbiter: round-robin sharing of one AND/OR evaluation unit with tagged valid/ready results
module intermed_wire_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_in_1,
    input  logic [NUM_REQ-1:0] req_in_2,
    input  logic [NUM_REQ-1:0] req_in_3,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_out_1,
    output logic               rsp_out_2,
    output logic [CNT_W-1:0]   txn_count
);
    typedef enum logic [1:0] {IDLE, GRANT, EVAL, RESP} state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] ptr, win, win_q, ptr_nx;
    logic            a_q, b_q, c_q, mid, out_1, out_2, take, done;

    // round-robin search: scan from the top offset down so the lowest offset from ptr wins
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NUM_REQ]) win = ID_W'((int'(ptr) + k) % NUM_REQ);
        ptr_nx = (int'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
    end

    // shared logic unit working on the captured operands
    always_comb begin
        mid   = a_q & b_q;
        out_1 = mid | c_q;
        out_2 = mid & b_q;
    end

    // next state and handshake qualifiers
    always_comb begin
        take     = (state == IDLE) && |req;
        done     = (state == RESP) && rsp_ready;
        state_nx = state;
        case (state)
            IDLE:    state_nx = take ? GRANT : IDLE;
            GRANT:   state_nx = EVAL;
            EVAL:    state_nx = RESP;
            default: state_nx = done ? IDLE : RESP;
        endcase
        busy = state != IDLE;
    end

    // state, capture, result and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            ptr       <= '0;
            win_q     <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            c_q       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out_1 <= 1'b0;
            rsp_out_2 <= 1'b0;
            txn_count <= '0;
        end else begin
            state <= state_nx;
            gnt   <= take ? NUM_REQ'(1) << win : '0;
            if (take) begin
                win_q <= win;
                ptr   <= ptr_nx;
                a_q   <= req_in_1[win];
                b_q   <= req_in_2[win];
                c_q   <= req_in_3[win];
            end
            if (state == EVAL) begin
                rsp_out_1 <= out_1;
                rsp_out_2 <= out_2;
                rsp_id    <= win_q;
                rsp_valid <= 1'b1;
            end
            if (done) begin
                rsp_valid <= 1'b0;
                txn_count <= txn_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_intermed_wire_arbiter.sv
// tb_intermed_wire_arbiter: directed and randomized checks against a transaction-level model
module tb_intermed_wire_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0, rst, rsp_ready;
    logic [N-1:0] req, in_1, in_2, in_3;
    logic [N-1:0] gnt, gnt2;
    logic         busy, busy2, rsp_valid, rsp_valid2, rsp_out_1, rsp_out_12, rsp_out_2, rsp_out_22;
    logic [1:0]   rsp_id, rsp_id2;
    logic [15:0]  txn_count;
    logic [1:0]   txn_count2;
    int           ncmp = 0, nerr = 0, ptr = 0, cnt = 0;

    intermed_wire_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_in_1(in_1), .req_in_2(in_2), .req_in_3(in_3),
        .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out_1(rsp_out_1), .rsp_out_2(rsp_out_2), .txn_count(txn_count));

    intermed_wire_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .req_in_1(in_1), .req_in_2(in_2), .req_in_3(in_3),
        .gnt(gnt2), .busy(busy2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2),
        .rsp_out_1(rsp_out_12), .rsp_out_2(rsp_out_22), .txn_count(txn_count2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic scramble;
        req  = N'($urandom);
        in_1 = N'($urandom);
        in_2 = N'($urandom);
        in_3 = N'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, rsp_valid, 0);
        chk({tag, "_id"}, rsp_id, 0);
        chk({tag, "_out1"}, rsp_out_1, 0);
        chk({tag, "_out2"}, rsp_out_2, 0);
        chk({tag, "_cnt"}, txn_count, 0);
        chk({tag, "_cnt2"}, txn_count2, 0);
    endtask

    task automatic txn(input logic [N-1:0] r, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] c, input int hold);
        int   w;
        logic ea, eb, ec;
        req = r; in_1 = a; in_2 = b; in_3 = c; rsp_ready = 1'($urandom);
        w = pick(r);
        tick;
        if (w < 0) begin
            chk("idle_gnt", gnt, 0);
            chk("idle_busy", busy, 0);
            return;
        end
        ea = a[w]; eb = b[w]; ec = c[w];
        ptr = (w + 1) % N;
        chk("grant_gnt", gnt, 32'(1) << w);
        chk("grant_gnt2", gnt2, 32'(1) << w);
        chk("grant_busy", busy, 1);
        chk("grant_valid", rsp_valid, 0);
        scramble;
        rsp_ready = 1'($urandom);
        tick;
        chk("eval_gnt", gnt, 0);
        chk("eval_busy", busy, 1);
        chk("eval_valid", rsp_valid, 0);
        scramble;
        rsp_ready = 1'($urandom);
        tick;
        for (int i = 0; i <= hold; i++) begin
            chk("resp_valid", rsp_valid, 1);
            chk("resp_id", rsp_id, w);
            chk("resp_out1", rsp_out_1, (ea & eb) | ec);
            chk("resp_out2", rsp_out_2, ea & eb);
            chk("resp_gnt", gnt, 0);
            chk("resp_busy", busy, 1);
            chk("resp_cnt", txn_count, cnt & 16'hffff);
            rsp_ready = (i == hold);
            if (i < hold) scramble;
            tick;
        end
        cnt++;
        chk("done_valid", rsp_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_cnt", txn_count, cnt & 16'hffff);
        chk("done_cnt2", txn_count2, cnt & 3);
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; in_1 = '0; in_2 = '0; in_3 = '0; rsp_ready = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        txn(4'b0000, '0, '0, '0, 0);
        txn(4'b0001, 4'b0001, 4'b0001, 4'b0000, 0);
        repeat (5) txn(4'b1111, N'($urandom), N'($urandom), N'($urandom), 0);
        txn(4'b0110, N'($urandom), N'($urandom), N'($urandom), 10);
        txn(4'b0110, N'($urandom), N'($urandom), N'($urandom), 0);
        for (int v = 0; v < 8; v++)
            txn(4'b0100, {1'b0, v[2], 2'b0}, {1'b0, v[1], 2'b0}, {1'b0, v[0], 2'b0}, v % 3);
        for (int t = 0; t < 40; t++)
            txn(N'($urandom), N'($urandom), N'($urandom), N'($urandom), int'($urandom_range(0, 3)));
        req = 4'b1000; in_1 = '1; in_2 = '1; in_3 = '1; rsp_ready = 1'b0;
        tick;
        req = '0;
        tick;
        tick;
        chk("abort_valid", rsp_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk_zero("abort");
        #1 rst = 1'b0;
        ptr = 0; cnt = 0;
        txn(4'b1111, 4'b0001, 4'b0001, 4'b0001, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
